// File: rtl/clk_div_pkg.sv
// Shared helpers for the multi-channel clock divider: channel-index width and default duty.
package clk_div_pkg;

    localparam int MAX_W = 32;

    // Width of a channel index; a single channel still needs a 1-bit select.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [MAX_W-1:0] hi_default(input logic [MAX_W-1:0] div);
        return div >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor and high-phase, pending flag.
// CLK_DIV_DUTY_EN adds a programmable high-phase input (cfg_hi).
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEF_DIV = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] cfg_hi,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(hi_default(MAX_W'(DEF_DIV)));

    logic [WIDTH-1:0] cnt, div_a, hi_a, div_s, hi_s;
    logic [WIDTH-1:0] d_eff, cnt_nx, hi_use, hi_new;
    logic             apply;

`ifdef CLK_DIV_DUTY_EN
    assign hi_new = cfg_hi;
`else
    assign hi_new = WIDTH'(hi_default(MAX_W'(cfg_div)));
`endif

    // Shadow config lands at a period boundary (wrap or sync) or while the channel is idle.
    always_comb begin
        d_eff  = (div_a == '0) ? WIDTH'(1) : div_a;
        cnt_nx = (cnt == d_eff - WIDTH'(1)) ? '0 : cnt + WIDTH'(1);
        apply  = pending & (sync | ~en | (cnt_nx == '0));
        hi_use = apply ? hi_s : hi_a;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            div_a   <= DEF_D;
            hi_a    <= DEF_H;
            div_s   <= DEF_D;
            hi_s    <= DEF_H;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (apply) begin
                div_a <= div_s;
                hi_a  <= hi_s;
            end
            if (cfg_we) begin
                div_s   <= cfg_div;
                hi_s    <= hi_new;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            if (sync) begin
                cnt     <= '0;
                tick    <= en;
                clk_out <= (hi_use != '0);
            end else if (en) begin
                cnt     <= cnt_nx;
                tick    <= (cnt_nx == '0);
                clk_out <= (cnt_nx < hi_use);
            end else begin
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock dividers with a shared valid/ready config port and sync strobe.
// CLK_DIV_DUTY_EN adds the cfg_hi port for per-channel programmable high-phase length.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int  NCH     = 4,
    parameter int  WIDTH   = 8,
    parameter int  DEF_DIV = 8,
    localparam int CHW     = ch_width(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [WIDTH-1:0] cfg_div,
`ifdef CLK_DIV_DUTY_EN
    input  logic [WIDTH-1:0] cfg_hi,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    localparam int           NPAD  = 1 << CHW;
    localparam logic [CHW:0] NCH_L = (CHW+1)'(NCH);

    logic [NPAD-1:0] pend_pad;
    logic            ch_ok;
    logic            accept;

    // Out-of-range channels are always ready so their requests are swallowed.
    assign pend_pad  = NPAD'(pending);
    assign ch_ok     = ({1'b0, cfg_ch} < NCH_L);
    assign cfg_ready = ~reset & (~ch_ok | ~pend_pad[cfg_ch]);
    assign accept    = cfg_valid & cfg_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .WIDTH   (WIDTH),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .en      (en[g]),
            .sync    (sync),
            .cfg_we  (accept & ch_ok & (cfg_ch == CHW'(g))),
            .cfg_div (cfg_div),
`ifdef CLK_DIV_DUTY_EN
            .cfg_hi  (cfg_hi),
`endif
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: expectations queued per step, compared after each edge.
// Duty-cycle steps are compiled only with CLK_DIV_DUTY_EN.
module tb_clk_div_multi;

    localparam int K_CO = 0, K_TK = 1, K_PD = 2, K_CO1 = 3, K_TK1 = 4, K_PD1 = 5, K_RDY = 6;

    typedef struct {
        string       tag;
        int          kind;
        int          ch;
        logic [15:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, sync, cfg_valid, cfg_ready;
    logic [3:0] en, clk_out, tick, pending;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_div;
`ifdef CLK_DIV_DUTY_EN
    logic [7:0] cfg_hi;
`endif

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] vc, vt;

    clk_div_multi #(.NCH(4), .WIDTH(8), .DEF_DIV(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
`ifdef CLK_DIV_DUTY_EN
        .cfg_hi    (cfg_hi),
`endif
        .clk_out   (clk_out),
        .tick      (tick),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] obs(input int kind, input int ch);
        case (kind)
            K_CO:    return 16'(clk_out);
            K_TK:    return 16'(tick);
            K_PD:    return 16'(pending);
            K_CO1:   return 16'(clk_out[ch]);
            K_TK1:   return 16'(tick[ch]);
            K_PD1:   return 16'(pending[ch]);
            default: return 16'(cfg_ready);
        endcase
    endfunction

    task automatic expv(input string tag, input int kind, input int ch, input logic [15:0] v);
        q.push_back('{tag, kind, ch, v});
    endtask

    task automatic drain();
        exp_t        e;
        logic [15:0] o;
        while (q.size() > 0) begin
            e = q.pop_front();
            o = obs(e.kind, e.ch);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s ch%0d observed=%0h expected=%0h", e.tag, e.ch, o, e.exp);
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    initial begin
        reset = 1'b1; en = 4'h0; sync = 1'b0; cfg_valid = 1'b0;
        cfg_ch = 2'd0; cfg_div = 8'd0;
`ifdef CLK_DIV_DUTY_EN
        cfg_hi = 8'd0;
`endif
        cyc();
        expv("rst_co", K_CO, 0, 16'h0);
        expv("rst_tk", K_TK, 0, 16'h0);
        expv("rst_pd", K_PD, 0, 16'h0);
        cyc();
        expv("rst_rdy", K_RDY, 0, 16'h0);
        settle();
        reset = 1'b0; en = 4'hF;
        expv("rdy_idle", K_RDY, 0, 16'h1);
        settle();

        // defaults: 4 high / 4 low, tick every 8 edges
        for (int k = 1; k <= 16; k++) begin
            expv("def_co", K_CO, 0, ((k % 8) < 4) ? 16'hF : 16'h0);
            expv("def_tk", K_TK, 0, ((k % 8) == 0) ? 16'hF : 16'h0);
            cyc();
        end

        // mid-period reconfig of ch1 to div 5
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
        expv("cfg1_rdy", K_RDY, 0, 16'h1);
        settle();
        expv("cfg1_pd", K_PD, 0, 16'h2);
        expv("cfg1_co", K_CO1, 1, 16'h1);
        cyc();
        cfg_valid = 1'b0;
        expv("cfg1_busy", K_RDY, 0, 16'h0);
        settle();
        cfg_ch = 2'd0;
        expv("cfg0_rdy", K_RDY, 0, 16'h1);
        settle();
        for (int k = 18; k <= 23; k++) begin
            expv("hold_pd", K_PD, 0, 16'h2);
            expv("hold_co1", K_CO1, 1, ((k % 8) < 4) ? 16'h1 : 16'h0);
            cyc();
        end
        expv("wrap_pd", K_PD, 0, 16'h0);
        expv("wrap_tk", K_TK, 0, 16'hF);
        expv("wrap_co1", K_CO1, 1, 16'h1);
        cyc();
        for (int j = 1; j <= 10; j++) begin
            expv("d5_co", K_CO1, 1, ((j % 5) < 2) ? 16'h1 : 16'h0);
            expv("d5_tk", K_TK1, 1, ((j % 5) == 0) ? 16'h1 : 16'h0);
            expv("d8_co", K_CO1, 0, (((24 + j) % 8) < 4) ? 16'h1 : 16'h0);
            cyc();
        end

        // sync aligns channels at different phases
        sync = 1'b1;
        expv("sync_tk", K_TK, 0, 16'hF);
        expv("sync_co", K_CO, 0, 16'hF);
        cyc();
        sync = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            vc[0] = ((j % 8) < 4); vc[1] = ((j % 5) < 2); vc[2] = vc[0]; vc[3] = vc[0];
            vt[0] = ((j % 8) == 0); vt[1] = ((j % 5) == 0); vt[2] = vt[0]; vt[3] = vt[0];
            expv("algn_co", K_CO, 0, 16'(vc));
            expv("algn_tk", K_TK, 0, 16'(vt));
            cyc();
        end

        // small divisors: ch0 div 2, ch3 div 1, then ch3 div 0
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd2;
        cyc();
        cfg_ch = 2'd3; cfg_div = 8'd1;
        cyc();
        cfg_valid = 1'b0; sync = 1'b1;
        expv("sd_tk", K_TK, 0, 16'hF);
        expv("sd_co", K_CO, 0, 16'h7);
        expv("sd_pd", K_PD, 0, 16'h0);
        cyc();
        sync = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            expv("d2_co", K_CO1, 0, ((j % 2) == 0) ? 16'h1 : 16'h0);
            expv("d2_tk", K_TK1, 0, ((j % 2) == 0) ? 16'h1 : 16'h0);
            expv("d1_tk", K_TK1, 3, 16'h1);
            expv("d1_co", K_CO1, 3, 16'h0);
            cyc();
        end
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd0;
        expv("d0_pd", K_PD1, 3, 16'h1);
        cyc();
        cfg_valid = 1'b0;
        expv("d0_apply", K_PD1, 3, 16'h0);
        cyc();
        for (int j = 1; j <= 3; j++) begin
            expv("d0_tk", K_TK1, 3, 16'h1);
            expv("d0_co", K_CO1, 3, 16'h0);
            cyc();
        end

        // disabled channel freezes and applies config on the next edge
        sync = 1'b1;
        cyc();
        sync = 1'b0;
        repeat (3) cyc();
        en = 4'b1011;
        expv("frz_co", K_CO1, 2, 16'h1);
        expv("frz_tk", K_TK1, 2, 16'h0);
        cyc();
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd6;
        expv("frz_pd", K_PD1, 2, 16'h1);
        expv("frz_co2", K_CO1, 2, 16'h1);
        cyc();
        cfg_valid = 1'b0;
        expv("frz_apply", K_PD1, 2, 16'h0);
        expv("frz_co3", K_CO1, 2, 16'h1);
        cyc();
        en = 4'hF;
        expv("d6_co_a", K_CO1, 2, 16'h0);
        expv("d6_tk_a", K_TK1, 2, 16'h0);
        cyc();
        expv("d6_co_b", K_CO1, 2, 16'h0);
        cyc();
        expv("d6_co_c", K_CO1, 2, 16'h1);
        expv("d6_tk_c", K_TK1, 2, 16'h1);
        cyc();

        // reset discards pending config on ch3
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd200;
        expv("r3_pd_a", K_PD1, 3, 16'h1);
        cyc();
        cfg_valid = 1'b0;
        expv("r3_pd_b", K_PD1, 3, 16'h0);
        cyc();
        cfg_valid = 1'b1; cfg_div = 8'd9;
        expv("r3_pd_c", K_PD1, 3, 16'h1);
        cyc();
        cfg_valid = 1'b0;
        expv("r3_pd_d", K_PD1, 3, 16'h1);
        cyc();
        reset = 1'b1;
        expv("r3_rdy", K_RDY, 0, 16'h0);
        settle();
        expv("r3_pd", K_PD, 0, 16'h0);
        expv("r3_co", K_CO, 0, 16'h0);
        expv("r3_tk", K_TK, 0, 16'h0);
        cyc();
        reset = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            expv("r3_def_co", K_CO, 0, ((j % 8) < 4) ? 16'hF : 16'h0);
            expv("r3_def_tk", K_TK, 0, (j == 8) ? 16'hF : 16'h0);
            cyc();
        end

`ifdef CLK_DIV_DUTY_EN
        // programmable duty: div 3 with hi 1, 0 and 3
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd3; cfg_hi = 8'd1;
        cyc();
        cfg_valid = 1'b0; sync = 1'b1;
        expv("h1_sync", K_CO1, 0, 16'h1);
        cyc();
        sync = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            expv("h1_co", K_CO1, 0, ((j % 3) == 0) ? 16'h1 : 16'h0);
            expv("h1_tk", K_TK1, 0, ((j % 3) == 0) ? 16'h1 : 16'h0);
            cyc();
        end
        cfg_valid = 1'b1; cfg_hi = 8'd0;
        cyc();
        cfg_valid = 1'b0; sync = 1'b1;
        expv("h0_sync", K_CO1, 0, 16'h0);
        cyc();
        sync = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            expv("h0_co", K_CO1, 0, 16'h0);
            cyc();
        end
        cfg_valid = 1'b1; cfg_hi = 8'd3;
        cyc();
        cfg_valid = 1'b0; sync = 1'b1;
        expv("h3_sync", K_CO1, 0, 16'h1);
        cyc();
        sync = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            expv("h3_co", K_CO1, 0, 16'h1);
            cyc();
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
Parametrised successor to the team's single-output 4-bit clock divider. It provides NCH independent programmable dividers, each producing a registered divided clock and a one-cycle tick. Divisor updates go through a valid/ready config port and take effect glitch-free at each channel's period boundary. A global sync strobe phase-aligns all channels. It sits in the clocking/timebase layer and feeds enables to peripherals; outputs are data-path signals, not gated clocks.

Parameters:
NCH, 4, number of divider channels (1..16)
WIDTH, 8, divisor/counter width in bits
DEF_DIV, 8, divisor loaded into every channel at reset

Ports:
clk  in  1  system clock, all logic posedge
reset  in  1  synchronous, active-high reset
en  in  NCH  per-channel count enable
sync  in  1  global phase-align strobe
cfg_valid  in  1  config request
cfg_ready  out  1  config accept; =!pending[cfg_ch] (1 if cfg_ch>=NCH); 0 while reset
cfg_ch  in  max(1,$clog2(NCH))  target channel
cfg_div  in  WIDTH  new divisor
cfg_hi  in  WIDTH  new high-phase length (only when CLK_DIV_DUTY_EN defined)
clk_out  out  NCH  divided clock, registered
tick  out  NCH  one-cycle pulse at period start, registered
pending  out  NCH  shadow config waiting to apply

Behaviour:
- Reset (sync, active-high): cnt=0, div_a=DEF_DIV, hi_a=DEF_DIV>>1, shadows=active, pending=0, clk_out=0, tick=0. Reset mid-operation discards pending config.
- Effective divisor d=max(div_a,1). Per enabled edge: cnt_next = (cnt==d-1) ? 0 : cnt+1.
- clk_out[i] <= (cnt_next < hi_a); tick[i] <= (cnt_next==0) on enabled edges, else 0. Example DIV=8: cnt 1..7,0; clk_out high while cnt in {0..3}; 8-cycle period.
- en[i]=0: cnt and clk_out hold; tick=0.
- sync=1 (priority over counting, not over reset): all channels cnt<=0; enabled channels tick<=1; clk_out<=(hi_a>0); disabled channels also reset cnt but tick=0.
- Config accept = cfg_valid & cfg_ready: shadow[cfg_ch]<=cfg_div (and cfg_hi), pending set. cfg_ch>=NCH: accepted and dropped.
- Apply (shadow->active, pending clear) on the edge where the channel wraps (cnt_next==0), on sync, or on any edge with en[i]=0. clk_out on that edge uses the new hi_a. Accept and apply never collide for one channel: ready is low while pending.
- div 0 or 1: tick every enabled cycle; clk_out follows hi rule (hi=0 -> constant 0).
- hi_a>=d: clk_out constant 1; hi_a=0: constant 0.

Optional Feature:
CLK_DIV_DUTY_EN: defined -> cfg_hi port exists and hi is programmable per channel. Undefined -> no cfg_hi port; hi = div>>1, so odd divisors have the low phase one cycle longer than the high phase.

Decomposition:
- Package clk_div_pkg: WIDTH-independent constants, channel-index typedef helper, default-duty function hi_default(div)=div>>1.
- Sub-module clk_div_chan: one channel (counter, active and shadow registers, pending flag, outputs). Top instantiates NCH copies via generate and decodes cfg_ch.

Test Plan:
- Reset then en=1, defaults: clk_out[0] 4 high/4 low, tick every 8 cycles, first tick 8 edges after en.
- Mid-period cfg ch1 div=5: pending[1]=1, cfg_ready=0 for ch1 until wrap; then period 5, 2 high/3 low (no duty macro).
- Channels at different phases, pulse sync: all enabled ticks in the same cycle, then aligned periods.
- div=2 -> clk_out toggles every cycle; div=1 and div=0 -> tick every cycle, clk_out=0.
- en[2]=0 mid-period: outputs freeze; cfg to ch2 applies on next edge (pending 1 cycle). Assert reset with pending on ch3: pending cleared, DEF_DIV restored.
- With CLK_DIV_DUTY_EN: div=3 hi=1 -> 1 high/2 low; hi=0 -> constant 0; hi=3 -> constant 1.
